// File: rtl/matrix_3x3_gen.sv
// 3x3 neighbourhood generator: two line buffers + 3-column window, 2-cycle pixel-to-window latency, no backpressure.
// Define MATRIX_ZERO_PAD_EN to force out-of-frame taps (top rows, left columns) to zero.
module matrix_3x3_gen #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int DATA_W    = 8
) (
    input  logic              clk_100M,
    input  logic              rst_p,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_y,
    output logic              matrix_frame_vsync,
    output logic              matrix_frame_href,
    output logic              matrix_frame_clken,
    output logic [DATA_W-1:0] matrix_p11,
    output logic [DATA_W-1:0] matrix_p12,
    output logic [DATA_W-1:0] matrix_p13,
    output logic [DATA_W-1:0] matrix_p21,
    output logic [DATA_W-1:0] matrix_p22,
    output logic [DATA_W-1:0] matrix_p23,
    output logic [DATA_W-1:0] matrix_p31,
    output logic [DATA_W-1:0] matrix_p32,
    output logic [DATA_W-1:0] matrix_p33
);
    localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam logic [AW-1:0] COL_LAST = AW'(IMG_HDISP - 1);

    if (IMG_VDISP < 1) begin : g_vdisp_chk
        $error("IMG_VDISP must be positive");
    end

    logic              accept, href_rise, href_fall, vs_rise;
    logic [AW-1:0]     col_cur, col_d, col_q;
    logic [1:0]        row_cur, row_d, row_q;
    logic              href_prev_d, href_prev_q, vsync_prev_d, vsync_prev_q;
    logic              s1_vld_d, s1_vld_q;
    logic [DATA_W-1:0] s1_pix_d, s1_pix_q;
    logic [AW-1:0]     s1_col_d, s1_col_q;
`ifdef MATRIX_ZERO_PAD_EN
    logic [1:0]        s1_row_d, s1_row_q;
`endif
    logic [1:0]        vs_pipe_d, vs_pipe_q, hr_pipe_d, hr_pipe_q;
    logic              clken_d, clken_q;
    logic [DATA_W-1:0] new_col [3];
    logic [DATA_W-1:0] win_d [3][3];
    logic [DATA_W-1:0] win_q [3][3];

    logic [DATA_W-1:0] line1_mem [IMG_HDISP];
    logic [DATA_W-1:0] line2_mem [IMG_HDISP];
    logic [DATA_W-1:0] l1_rd_q, l2_rd_q;

    always_comb begin
        accept       = per_frame_href & per_frame_clken;
        href_rise    = per_frame_href & ~href_prev_q;
        href_fall    = ~per_frame_href & href_prev_q;
        vs_rise      = per_frame_vsync & ~vsync_prev_q;
        href_prev_d  = per_frame_href;
        vsync_prev_d = per_frame_vsync;
        // Edges take effect in the same cycle so the first pixel of a line/frame lands at col 0 / row 0.
        col_cur = href_rise ? '0 : col_q;
        row_cur = vs_rise ? 2'd0 : row_q;

        col_d = col_cur;
        if (accept) begin
            col_d = (col_cur == COL_LAST) ? '0 : col_cur + AW'(1);
        end
        row_d = row_cur;
        if (href_fall && per_frame_vsync && (row_cur != 2'd2)) begin
            row_d = row_cur + 2'd1;
        end

        s1_vld_d = accept;
        s1_pix_d = accept ? per_img_y : s1_pix_q;
        s1_col_d = accept ? col_cur : s1_col_q;
`ifdef MATRIX_ZERO_PAD_EN
        s1_row_d = accept ? row_cur : s1_row_q;
`endif

        new_col[0] = l2_rd_q;
        new_col[1] = l1_rd_q;
        new_col[2] = s1_pix_q;
`ifdef MATRIX_ZERO_PAD_EN
        if (s1_row_q == 2'd0) begin
            new_col[0] = '0;
            new_col[1] = '0;
        end else if (s1_row_q == 2'd1) begin
            new_col[0] = '0;
        end
`endif

        win_d = win_q;
        if (s1_vld_q) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
                win_d[r][2] = new_col[r];
`ifdef MATRIX_ZERO_PAD_EN
                if (s1_col_q == '0) begin
                    win_d[r][0] = '0;
                    win_d[r][1] = '0;
                end else if (s1_col_q == AW'(1)) begin
                    win_d[r][0] = '0;
                end
`endif
            end
        end

        vs_pipe_d = {vs_pipe_q[0], per_frame_vsync};
        hr_pipe_d = {hr_pipe_q[0], per_frame_href};
        clken_d   = s1_vld_q;
    end

    always_ff @(posedge clk_100M) begin
        if (rst_p) begin
            col_q        <= '0;
            row_q        <= '0;
            href_prev_q  <= 1'b0;
            vsync_prev_q <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_pix_q     <= '0;
            s1_col_q     <= '0;
`ifdef MATRIX_ZERO_PAD_EN
            s1_row_q     <= '0;
`endif
            vs_pipe_q    <= '0;
            hr_pipe_q    <= '0;
            clken_q      <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            href_prev_q  <= href_prev_d;
            vsync_prev_q <= vsync_prev_d;
            s1_vld_q     <= s1_vld_d;
            s1_pix_q     <= s1_pix_d;
            s1_col_q     <= s1_col_d;
`ifdef MATRIX_ZERO_PAD_EN
            s1_row_q     <= s1_row_d;
`endif
            vs_pipe_q    <= vs_pipe_d;
            hr_pipe_q    <= hr_pipe_d;
            clken_q      <= clken_d;
            win_q        <= win_d;
        end
    end

    // Line buffers: line2 is written one cycle late with the registered line1 read, same address.
    always_ff @(posedge clk_100M) begin
        if (accept) begin
            l1_rd_q            <= line1_mem[col_cur];
            l2_rd_q            <= line2_mem[col_cur];
            line1_mem[col_cur] <= per_img_y;
        end
        if (s1_vld_q) begin
            line2_mem[s1_col_q] <= l1_rd_q;
        end
    end

    assign matrix_frame_vsync = vs_pipe_q[1];
    assign matrix_frame_href  = hr_pipe_q[1];
    assign matrix_frame_clken = clken_q;
    assign matrix_p11 = win_q[0][0];
    assign matrix_p12 = win_q[0][1];
    assign matrix_p13 = win_q[0][2];
    assign matrix_p21 = win_q[1][0];
    assign matrix_p22 = win_q[1][1];
    assign matrix_p23 = win_q[1][2];
    assign matrix_p31 = win_q[2][0];
    assign matrix_p32 = win_q[2][1];
    assign matrix_p33 = win_q[2][2];
endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Directed bench for matrix_3x3_gen with an 8-pixel line; expectations follow MATRIX_ZERO_PAD_EN if defined.
module tb_matrix_3x3_gen;
    logic clk_100M = 1'b0;
    always #5 clk_100M = ~clk_100M;

    logic       rst_p, per_frame_vsync, per_frame_href, per_frame_clken;
    logic [7:0] per_img_y;
    logic       matrix_frame_vsync, matrix_frame_href, matrix_frame_clken;
    logic [7:0] matrix_p11, matrix_p12, matrix_p13;
    logic [7:0] matrix_p21, matrix_p22, matrix_p23;
    logic [7:0] matrix_p31, matrix_p32, matrix_p33;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int g0;
    logic [7:0] rp [0:1023][0:8];
    logic       rck [0:1023];
    logic       rhr [0:1023];
    logic       rvs [0:1023];
    logic       in_hr [0:1023];
    logic       in_ck [0:1023];
    logic       in_vs [0:1023];
    int         pix_cyc [0:15];

    matrix_3x3_gen #(.IMG_HDISP(8), .IMG_VDISP(4), .DATA_W(8)) dut (
        .clk_100M(clk_100M), .rst_p(rst_p),
        .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
        .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
        .matrix_frame_vsync(matrix_frame_vsync), .matrix_frame_href(matrix_frame_href),
        .matrix_frame_clken(matrix_frame_clken),
        .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
        .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
        .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Applies one cycle of inputs; outputs seen after the edge are logged under the new cycle index.
    task automatic drive(input logic rs, input logic vs, input logic hr, input logic ck, input logic [7:0] px);
        rst_p = rs; per_frame_vsync = vs; per_frame_href = hr; per_frame_clken = ck; per_img_y = px;
        in_vs[cyc_n] = vs; in_hr[cyc_n] = hr; in_ck[cyc_n] = hr & ck;
        @(posedge clk_100M);
        #1;
        cyc_n++;
        rp[cyc_n][0] = matrix_p11; rp[cyc_n][1] = matrix_p12; rp[cyc_n][2] = matrix_p13;
        rp[cyc_n][3] = matrix_p21; rp[cyc_n][4] = matrix_p22; rp[cyc_n][5] = matrix_p23;
        rp[cyc_n][6] = matrix_p31; rp[cyc_n][7] = matrix_p32; rp[cyc_n][8] = matrix_p33;
        rck[cyc_n] = matrix_frame_clken; rhr[cyc_n] = matrix_frame_href; rvs[cyc_n] = matrix_frame_vsync;
    endtask

    task automatic send_line(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            pix_cyc[i] = cyc_n;
            drive(1'b0, 1'b1, 1'b1, 1'b1, base + 8'(i));
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_all_zero(input string tag);
        for (int k = 0; k < 9; k++) chk(tag, rp[cyc_n][k], 0);
        chk(tag, rck[cyc_n], 0);
        chk(tag, rhr[cyc_n], 0);
        chk(tag, rvs[cyc_n], 0);
    endtask

    initial begin
        int n;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk_all_zero("reset");

        // Frame 1: vsync and href rise together; pixel = 16*line + col.
        send_line(8, 8'h00);
        for (int c = 0; c < 8; c++) begin
            n = pix_cyc[c] + 2;
            chk("l0_p33", rp[n][8], c);
            chk("l0_clken", rck[n], 1);
`ifdef MATRIX_ZERO_PAD_EN
            chk("l0_p13", rp[n][2], 0);
            chk("l0_p23", rp[n][5], 0);
            if (c == 0) begin
                chk("l0c0_p21", rp[n][3], 0);
                chk("l0c0_p22", rp[n][4], 0);
                chk("l0c0_p31", rp[n][6], 0);
                chk("l0c0_p32", rp[n][7], 0);
            end
`endif
        end
        send_line(8, 8'h10);
        n = pix_cyc[3] + 2;
        chk("l1c3_p33", rp[n][8], 8'h13);
        chk("l1c3_p23", rp[n][5], 8'h03);
`ifdef MATRIX_ZERO_PAD_EN
        chk("l1c3_p13", rp[n][2], 0);
`endif
        send_line(8, 8'h20);
        n = pix_cyc[3] + 2;
        chk("l2c3_p33", rp[n][8], 8'h23);
        chk("l2c3_p23", rp[n][5], 8'h13);
        chk("l2c3_p13", rp[n][2], 8'h03);
        chk("l2c3_p32", rp[n][7], 8'h22);
        chk("l2c3_p11", rp[n][0], 8'h01);
        chk("l2c3_clken", rck[n], 1);

        // Gapped enable: only even cycles carry a pixel.
        g0 = cyc_n;
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1, (i % 2) == 0, 8'h40 + 8'(i));
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = g0 - 1; k < g0 + 10; k++) begin
            chk("gap_clken", rck[k + 2], in_ck[k]);
            chk("gap_href", rhr[k + 2], in_hr[k]);
            chk("gap_vsync", rvs[k + 2], in_vs[k]);
        end
        for (int i = 0; i < 8; i++) chk("gap_p33", rp[g0 + i + 2][8], 8'h40 + 8'(i & ~1));

        // Frame 2: 10 pixels on an 8-wide line wrap onto addresses 0 and 1.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        send_line(10, 8'h50);
        chk("wrap_p33_8", rp[pix_cyc[8] + 2][8], 8'h58);
        chk("wrap_p33_9", rp[pix_cyc[9] + 2][8], 8'h59);
        send_line(8, 8'h60);
        chk("wrap_c0_p23", rp[pix_cyc[0] + 2][5], 8'h58);
        chk("wrap_c1_p23", rp[pix_cyc[1] + 2][5], 8'h59);
        chk("wrap_c2_p23", rp[pix_cyc[2] + 2][5], 8'h52);
`ifdef MATRIX_ZERO_PAD_EN
        chk("row1_p13", rp[pix_cyc[4] + 2][2], 0);
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Frame 3: reset after four pixels of line 2.
        send_line(8, 8'h90);
        send_line(8, 8'hA0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hB0 + 8'(i));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk_all_zero("midreset");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Frame 4: line 0 over line buffers still holding frame 3 data.
        send_line(8, 8'hC0);
        for (int c = 0; c < 8; c++) begin
            n = pix_cyc[c] + 2;
            chk("f4_p33", rp[n][8], 8'hC0 + 8'(c));
`ifdef MATRIX_ZERO_PAD_EN
            chk("f4_p13", rp[n][2], 0);
            chk("f4_p23", rp[n][5], 0);
`else
            chk("f4_p23_stale", rp[n][5], (c < 4) ? (8'hB0 + 8'(c)) : (8'hA0 + 8'(c)));
`endif
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
